// File: rtl/jt49_tone_sched.sv
// jt49_tone_sched: three PSG tone channels share one divider datapath.
// The datapath serves the channels in round-robin order, one channel per cen
// cycle. Each channel keeps its own count, div and period registers.
// Optional feature: define JT49_SCHED_PHASE_RST_EN so that a period write
// also restarts that channel's count at 1.
module jt49_tone_sched #(
  parameter int W   = 12,
  parameter int NCH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [NCH-1:0]   ch_en,
  input  logic             wr,
  input  logic [1:0]       wr_addr,
  input  logic [W-1:0]     wr_data,
  output logic             wr_ack,
  output logic [NCH-1:0]   div,
  output logic [NCH-1:0]   tick,
  output logic [1:0]       slot
);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} slot_t;

  slot_t                   slot_q, slot_d;
  logic [NCH-1:0][W-1:0]   count_q, count_d;
  logic [NCH-1:0][W-1:0]   period_q, period_d;
  logic [NCH-1:0]          div_q, div_d;
  logic [NCH-1:0]          tick_q, tick_d;
  logic                    wr_ack_q;

  logic [W-1:0]            sel_cnt, sel_per;
  logic                    sel_hit;
  logic [W-1:0]            one_w;

  assign one_w = {{(W-1){1'b0}}, 1'b1};

  // Slot sequencer: S0 -> S1 -> S2 -> S0. It moves only on cen cycles.
  always_comb begin
    slot_d = slot_q;
    if (cen) begin
      case (slot_q)
        S0:      slot_d = S1;
        S1:      slot_d = S2;
        default: slot_d = S0;
      endcase
    end
  end

  // Shared datapath. Pick the serviced channel's count and period, then
  // compare them once. The state register holds only S0..S2, so the
  // default branch always selects channel 2.
  always_comb begin
    sel_cnt = count_q[2];
    sel_per = period_q[2];
    case (slot_q)
      S0:      begin sel_cnt = count_q[0]; sel_per = period_q[0]; end
      S1:      begin sel_cnt = count_q[1]; sel_per = period_q[1]; end
      default: begin sel_cnt = count_q[2]; sel_per = period_q[2]; end
    endcase
    sel_hit = (sel_cnt >= sel_per);
  end

  // Per-channel register bank update. Each channel uses the shared compare
  // result only while it owns the slot.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic svc, wr_hit;
    assign svc    = cen && (slot_q == k[1:0]);
    assign wr_hit = wr && (wr_addr == k[1:0]);

    // Next state for channel k: service result, period load, optional phase restart
    always_comb begin
      count_d[k]  = count_q[k];
      div_d[k]    = div_q[k];
      tick_d[k]   = 1'b0;
      period_d[k] = period_q[k];
      if (svc) begin
        if (!ch_en[k]) begin
          count_d[k] = one_w;
          div_d[k]   = 1'b0;
        end else if (sel_hit) begin
          count_d[k] = one_w;
          div_d[k]   = ~div_q[k];
          tick_d[k]  = 1'b1;
        end else begin
          count_d[k] = count_q[k] + one_w;
        end
      end
      // The compare above used the old period, so the new value first
      // applies at this channel's next service.
      if (wr_hit) begin
        period_d[k] = wr_data;
`ifdef JT49_SCHED_PHASE_RST_EN
        // A write restarts the half-cycle and cancels any same-cycle service.
        count_d[k] = one_w;
        div_d[k]   = div_q[k];
        tick_d[k]  = 1'b0;
`endif
      end
    end
  end

  // State registers. Reset restores every register immediately, including
  // a write that is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= S0;
      count_q  <= {NCH{one_w}};
      period_q <= '0;
      div_q    <= '0;
      tick_q   <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      count_q  <= count_d;
      period_q <= period_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      wr_ack_q <= wr;
    end
  end

  assign wr_ack = wr_ack_q;
  assign div    = div_q;
  assign tick   = tick_q;
  assign slot   = slot_q;

endmodule

// File: tb/tb_jt49_tone_sched.sv
// Randomized bench for jt49_tone_sched with a cycle-level reference model.
// It also has directed checks on toggle rate, write-port behaviour and reset.
module tb_jt49_tone_sched;
  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic [2:0]    ch_en = 3'b000;
  logic          wr = 1'b0;
  logic [1:0]    wr_addr = 2'd0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ack;
  logic [2:0]    div, tick;
  logic [1:0]    slot;

  int total = 0;
  int bad   = 0;

  // Reference model state, held as plain integers
  int m_cnt[3];
  int m_per[3];
  int m_div[3];
  int m_tick[3];
  int m_slot;
  int m_ack;

  jt49_tone_sched #(.W(W), .NCH(3)) dut (
    .clk(clk), .rst(rst), .cen(cen), .ch_en(ch_en),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .div(div), .tick(tick), .slot(slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] pack3(input int a[3]);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (a[i] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 1; m_per[i] = 0; m_div[i] = 0; m_tick[i] = 0;
    end
    m_slot = 0;
    m_ack  = 0;
  endtask

  // One clock edge of the model.
  task automatic model_step(input logic c, input logic [2:0] e, input logic w,
                            input int a, input int d);
    int k;
    bit skip;
    for (int i = 0; i < 3; i++) m_tick[i] = 0;
    if (c) begin
      k = m_slot;
      skip = 0;
`ifdef JT49_SCHED_PHASE_RST_EN
      skip = w && (a == k);
`endif
      if (!skip) begin
        if (!e[k]) begin
          m_cnt[k] = 1; m_div[k] = 0;
        end else if (m_cnt[k] >= m_per[k]) begin
          m_cnt[k] = 1; m_div[k] = 1 - m_div[k]; m_tick[k] = 1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      m_slot = (m_slot + 1) % 3;
    end
    m_ack = w;
    if (w && a < 3) begin
      m_per[a] = d;
`ifdef JT49_SCHED_PHASE_RST_EN
      m_cnt[a] = 1;
`endif
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, then check the outputs.
  task automatic cyc(input logic c, input logic [2:0] e, input logic w,
                     input logic [1:0] a, input logic [W-1:0] d);
    cen = c; ch_en = e; wr = w; wr_addr = a; wr_data = d;
    model_step(c, e, w, int'(a), int'(d));
    @(posedge clk); #1;
    chk("div",    {29'd0, div},    {29'd0, pack3(m_div)});
    chk("tick",   {29'd0, tick},   {29'd0, pack3(m_tick)});
    chk("slot",   {30'd0, slot},   m_slot);
    chk("wr_ack", {31'd0, wr_ack}, m_ack);
  endtask

  // Assert reset between edges and check that it clears the outputs at once.
  task automatic do_reset();
    rst = 1'b1; cen = 1'b0; wr = 1'b0;
    #1;
    chk("rst_div",   {29'd0, div},    32'd0);
    chk("rst_tick",  {29'd0, tick},   32'd0);
    chk("rst_slot",  {30'd0, slot},   32'd0);
    chk("rst_ack",   {31'd0, wr_ack}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int toggles;
  logic [2:0] prev_div;

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Periods 0, all channels enabled: a tick every clk, rotating A,B,C.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 3'b111, 1'b0, 2'd0, '0);
      chk("stagger", {29'd0, tick}, 32'(1 << ((i) % 3)));
    end

    // Period A=4, B and C disabled: expect 2 toggles of div[0] in 24 clks.
    do_reset();
    cyc(1'b0, 3'b001, 1'b1, 2'd0, 12'd4);
    toggles = 0; prev_div = div;
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, 3'b001, 1'b0, 2'd0, '0);
      if (div[0] != prev_div[0]) toggles++;
      prev_div = div;
    end
    chk("rateA4", toggles, 2);
    chk("bc_idle", {30'd0, div[2:1]}, 32'd0);

    // cen on every other clk with period A=2: expect 4 toggles in 48 clks.
    do_reset();
    cyc(1'b0, 3'b001, 1'b1, 2'd0, 12'd2);
    toggles = 0; prev_div = div;
    for (int i = 0; i < 48; i++) begin
      cyc(i[0] == 1'b0, 3'b001, 1'b0, 2'd0, '0);
      if (div[0] != prev_div[0]) toggles++;
      prev_div = div;
    end
    chk("rate_cen", toggles, 4);

    // Count A reaches 3 with period 5, then A is written to 1 on its own
    // service cycle. The model checks the old-period compare.
    do_reset();
    cyc(1'b0, 3'b111, 1'b1, 2'd0, 12'd5);
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'b001, 1'b0, 2'd0, '0);
    cyc(1'b1, 3'b001, 1'b1, 2'd0, 12'd1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'b001, 1'b0, 2'd0, '0);

    // Writes to address 3 change nothing, but wr_ack still pulses.
    cyc(1'b1, 3'b111, 1'b1, 2'd3, 12'hFFF);
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'b111, 1'b0, 2'd0, '0);

    // Random traffic checked against the model
    for (int i = 0; i < 900; i++) begin
      logic c, w;
      logic [2:0] e;
      logic [1:0] a;
      logic [W-1:0] d;
      c = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
      w = ($urandom_range(0, 9) == 0);
      a = 2'($urandom);
      d = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      cyc(c, e, w, a, d);
      if (i == 500) do_reset();
    end

    // Reset in the middle of a write with the channels running
    cen = 1'b1; wr = 1'b1; wr_addr = 2'd1; wr_data = 12'd3;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'b111, 1'b0, 2'd0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound on the whole run
  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
